// File: rtl/level_sequencer.sv
// level_sequencer: game controller that picks the active level, drives its reset,
// turns key presses into jump pulses and handles death, checkpoint and win.
module level_sequencer #(
  parameter int NLV          = 3,
  parameter int FLASH_FRAMES = 30,
  parameter int FW           = 6
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           imgReturn,
  input  logic           key,
  input  logic [NLV-1:0] lvDeath,
  input  logic [NLV-1:0] lvCp,
  output logic [1:0]     lvSel,
  output logic           lvRst,
  output logic           jump,
  output logic           restart,
  output logic [11:0]    topColor,
  output logic [11:0]    midColor,
  output logic [7:0]     deaths,
  output logic           gameWin
);

  typedef enum logic [2:0] {
    IDLE, LOAD, PLAY, DEAD, ADVANCE, WIN
  } state_t;

  state_t        state, state_n;
  logic          key_q, key_rise;
  logic [FW-1:0] fcnt, fcnt_n;
  logic [1:0]    sel_n;
  logic [7:0]    deaths_n;
  logic [11:0]   top_b, mid_b;
  logic [11:0]   top_n, mid_n;

  assign key_rise = key & ~key_q;

  always_comb begin
    state_n  = state;
    sel_n    = lvSel;
    fcnt_n   = fcnt;
    deaths_n = deaths;
    unique case (state)
      IDLE: begin
        sel_n = '0;
        if (key_rise) begin
          state_n  = LOAD;
          deaths_n = '0;
        end
      end
      LOAD: begin
        fcnt_n  = '0;
        state_n = PLAY;
      end
      PLAY: begin
        // death wins over a same-cycle checkpoint
        if (lvDeath[lvSel]) begin
          state_n = DEAD;
          if (deaths != 8'hFF)
            deaths_n = deaths + 8'd1;
        end else if (lvCp[lvSel]) begin
          state_n = ADVANCE;
        end
      end
      DEAD: begin
        if (imgReturn) begin
          if (fcnt == FW'(FLASH_FRAMES - 1)) begin
            state_n = LOAD;
            fcnt_n  = '0;
          end else begin
            fcnt_n = fcnt + FW'(1);
          end
        end
      end
      ADVANCE: begin
        if (lvSel == 2'(NLV - 1)) begin
          state_n = WIN;
        end else begin
          sel_n   = lvSel + 2'd1;
          state_n = LOAD;
        end
      end
      WIN: begin
        if (key_rise) begin
          state_n = IDLE;
          sel_n   = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    top_b = '0;
    mid_b = '0;
    case (sel_n)
      2'd0: begin top_b = 12'h00F; mid_b = 12'h0F0; end
      2'd1: begin top_b = 12'hF00; mid_b = 12'h0FF; end
      2'd2: begin top_b = 12'hFF0; mid_b = 12'h808; end
      default: ;
    endcase
    top_n = top_b;
    mid_n = mid_b;
    if (state_n == IDLE || state_n == WIN) begin
      top_n = '0;
      mid_n = '0;
    end else if (state_n == DEAD && fcnt_n[2]) begin
      top_n = mid_b;
      mid_n = top_b;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      key_q    <= 1'b0;
      fcnt     <= '0;
      lvSel    <= '0;
      lvRst    <= 1'b0;
      jump     <= 1'b0;
      restart  <= 1'b0;
      topColor <= '0;
      midColor <= '0;
      deaths   <= '0;
      gameWin  <= 1'b0;
    end else begin
      state    <= state_n;
      key_q    <= key;
      fcnt     <= fcnt_n;
      lvSel    <= sel_n;
      lvRst    <= (state_n == PLAY) || (state_n == DEAD) ||
                  (state_n == ADVANCE);
      jump     <= (state == PLAY) && key_rise;
      restart  <= (state_n == DEAD);
      topColor <= top_n;
      midColor <= mid_n;
      deaths   <= deaths_n;
      gameWin  <= (state_n == WIN);
    end
  end

endmodule

// File: tb/tb_level_sequencer.sv
// tb_level_sequencer: directed stimulus with an in-bench reference model
// compared on every falling edge, plus hand-computed literal checks.
module tb_level_sequencer;

  localparam int NLV   = 3;
  localparam int FLASH = 30;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           imgReturn = 1'b0;
  logic           key = 1'b0;
  logic [NLV-1:0] lvDeath = '0;
  logic [NLV-1:0] lvCp = '0;
  logic [1:0]     lvSel;
  logic           lvRst, jump, restart, gameWin;
  logic [11:0]    topColor, midColor;
  logic [7:0]     deaths;

  int total = 0;
  int bad   = 0;
  int jcnt  = 0;

  level_sequencer #(.NLV(NLV), .FLASH_FRAMES(FLASH), .FW(6)) dut (
    .clk(clk), .rst(rst), .imgReturn(imgReturn), .key(key),
    .lvDeath(lvDeath), .lvCp(lvCp), .lvSel(lvSel), .lvRst(lvRst),
    .jump(jump), .restart(restart), .topColor(topColor),
    .midColor(midColor), .deaths(deaths), .gameWin(gameWin)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: game phase, level number, pulses seen while dead.
  localparam int P_IDLE = 0, P_LOAD = 1, P_PLAY = 2;
  localparam int P_DEAD = 3, P_ADV = 4, P_WIN = 5;

  int pal_top [3] = '{12'h00F, 12'hF00, 12'hFF0};
  int pal_mid [3] = '{12'h0F0, 12'h0FF, 12'h808};

  int m_phase = P_IDLE;
  int m_level = 0;
  int m_deaths = 0;
  int m_pulses = 0;
  bit m_keyq = 0;
  bit m_jump = 0;
  bit m_valid = 0;

  always @(posedge clk) begin
    bit rise;
    if (!rst) begin
      m_phase = P_IDLE; m_level = 0; m_deaths = 0;
      m_pulses = 0; m_keyq = 0; m_jump = 0; m_valid = 1;
    end else begin
      rise   = key && !m_keyq;
      m_jump = (m_phase == P_PLAY) && rise;
      case (m_phase)
        P_IDLE: if (rise) begin m_phase = P_LOAD; m_deaths = 0; end
        P_LOAD: begin m_phase = P_PLAY; m_pulses = 0; end
        P_PLAY:
          if (lvDeath[m_level]) begin
            m_phase = P_DEAD;
            m_deaths = (m_deaths + 1 > 255) ? 255 : m_deaths + 1;
          end else if (lvCp[m_level]) begin
            m_phase = P_ADV;
          end
        P_DEAD:
          if (imgReturn) begin
            m_pulses++;
            if (m_pulses == FLASH) begin
              m_phase = P_LOAD; m_pulses = 0;
            end
          end
        P_ADV:
          if (m_level == NLV - 1) m_phase = P_WIN;
          else begin m_level++; m_phase = P_LOAD; end
        P_WIN: if (rise) begin m_phase = P_IDLE; m_level = 0; end
        default: ;
      endcase
      m_keyq = key;
    end
  end

  always @(negedge clk) begin
    int et, em;
    bit busy;
    if (m_valid) begin
      busy = (m_phase == P_PLAY) || (m_phase == P_DEAD) ||
             (m_phase == P_ADV);
      et = pal_top[m_level];
      em = pal_mid[m_level];
      if (m_phase == P_IDLE || m_phase == P_WIN) begin
        et = 0; em = 0;
      end else if (m_phase == P_DEAD && ((m_pulses / 4) % 2 == 1)) begin
        et = pal_mid[m_level]; em = pal_top[m_level];
      end
      chk("lvSel", 32'(lvSel), 32'(m_level));
      chk("lvRst", 32'(lvRst), 32'(busy));
      chk("jump", 32'(jump), 32'(m_jump));
      chk("restart", 32'(restart), 32'(m_phase == P_DEAD));
      chk("gameWin", 32'(gameWin), 32'(m_phase == P_WIN));
      chk("deaths", 32'(deaths), 32'(m_deaths));
      chk("topColor", 32'(topColor), 32'(et));
      chk("midColor", 32'(midColor), 32'(em));
      if (jump === 1'b1) jcnt++;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic flash(input int gap, input bit probe);
    for (int i = 0; i < FLASH; i++) begin
      imgReturn = 1'b1;
      step(1);
      imgReturn = 1'b0;
      if (probe && i == 3) chk("flash_swap_top", 32'(topColor), 32'h0F0);
      if (probe && i == FLASH - 2) chk("flash_still", 32'(restart), 32'd1);
      if (probe && i == FLASH - 1) begin
        chk("reload_restart", 32'(restart), 32'd0);
        chk("reload_lvrst", 32'(lvRst), 32'd0);
      end
      step(gap);
    end
  endtask

  initial begin
    step(2);
    chk("reset_lvrst", 32'(lvRst), 32'd0);
    chk("reset_top", 32'(topColor), 32'd0);
    rst = 1'b1;
    step(1);

    key = 1'b1; step(1);
    chk("start_load_lvrst", 32'(lvRst), 32'd0);
    step(1);
    chk("start_play_lvrst", 32'(lvRst), 32'd1);
    chk("start_top", 32'(topColor), 32'h00F);
    chk("start_mid", 32'(midColor), 32'h0F0);
    key = 1'b0; step(2);

    key = 1'b1; step(1);
    chk("jump_first", 32'(jump), 32'd1);
    step(10);
    key = 1'b0; step(2);
    key = 1'b1; step(1);
    key = 1'b0; step(3);
    chk("jump_count", 32'(jcnt), 32'd2);

    lvDeath = 3'b001; step(1); lvDeath = '0;
    chk("death_count", 32'(deaths), 32'd1);
    chk("death_restart", 32'(restart), 32'd1);
    flash(3, 1'b1);
    chk("reload_play_sel", 32'(lvSel), 32'd0);
    chk("reload_play_rst", 32'(lvRst), 32'd1);

    lvDeath = 3'b001; lvCp = 3'b001; step(1);
    lvDeath = '0; lvCp = '0;
    chk("prio_restart", 32'(restart), 32'd1);
    chk("prio_deaths", 32'(deaths), 32'd2);
    flash(1, 1'b0);

    lvCp = 3'b100; step(1); lvCp = '0; step(2);
    chk("mask_sel", 32'(lvSel), 32'd0);
    chk("mask_rst", 32'(lvRst), 32'd1);

    lvCp = 3'b001; step(1); lvCp = '0; step(2);
    chk("adv1_sel", 32'(lvSel), 32'd1);
    chk("adv1_top", 32'(topColor), 32'hF00);
    chk("adv1_mid", 32'(midColor), 32'h0FF);
    lvCp = 3'b010; step(1); lvCp = '0; step(2);
    chk("adv2_sel", 32'(lvSel), 32'd2);
    chk("adv2_top", 32'(topColor), 32'hFF0);
    chk("adv2_mid", 32'(midColor), 32'h808);
    lvCp = 3'b100; step(1); lvCp = '0; step(1);
    chk("win_flag", 32'(gameWin), 32'd1);
    chk("win_lvrst", 32'(lvRst), 32'd0);
    chk("win_top", 32'(topColor), 32'd0);
    key = 1'b1; step(1); key = 1'b0; step(1);
    chk("idle_win", 32'(gameWin), 32'd0);
    chk("idle_sel", 32'(lvSel), 32'd0);

    key = 1'b1; step(1); key = 1'b0; step(1);
    chk("restart_deaths_clr", 32'(deaths), 32'd0);
    for (int d = 0; d < 260; d++) begin
      lvDeath = 3'b001; step(1); lvDeath = '0;
      flash(1, 1'b0);
    end
    chk("sat_deaths", 32'(deaths), 32'd255);

    lvDeath = 3'b001; step(1); lvDeath = '0; step(2);
    rst = 1'b0; step(1); rst = 1'b1;
    chk("midrst_restart", 32'(restart), 32'd0);
    chk("midrst_deaths", 32'(deaths), 32'd0);
    chk("midrst_lvrst", 32'(lvRst), 32'd0);
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
